radix2_bf_dl2: RTL and testbench
================================

RADIX2_BF_DL2 -- requirements
Module: radix2_bf_dl2

Radix-2 SDF butterfly for the 4-point stage (feedback delay depth 2). Drives and consumes an external 2-deep delay line (shift_2).

Interface
REQ-001 Parameter WIDTH, default 24, sample width of real and imaginary parts (signed two's complement).
REQ-002 Parameter SCALE, default 0; 1 = butterfly sum/difference divided by 2 (arithmetic shift right, truncate).
REQ-003 clk  input  1  single clock, all logic on rising edge.
REQ-004 reset_n  input  1  asynchronous active-low reset.
REQ-005 in_valid  input  1  din_r/din_i carry a sample this cycle.
REQ-006 din_r, din_i  input  WIDTH each  signed input sample.
REQ-007 dly_r, dly_i  input  WIDTH each  signed sample returning from the delay line (its dout).
REQ-008 dly_en  output  1  shift strobe to the delay line (its in_valid).
REQ-009 to_dly_r, to_dly_i  output  WIDTH each  signed sample written into the delay line (its din), combinational.
REQ-010 dout_r, dout_i  output  WIDTH each  registered signed stage output.
REQ-011 out_valid  output  1  registered; dout carries a sample derived from at least one valid input.

Function
REQ-012 FSM states: IDLE, RUN. IDLE -> RUN on in_valid=1. RUN is held until reset. No other transitions.
REQ-013 2-bit counter cnt. Held at 0 in IDLE. The accepting IDLE cycle is cnt=0. cnt increments every RUN cycle and wraps 3 -> 0.
REQ-014 In RUN, cnt advances every cycle regardless of in_valid (the delay line free-runs). A cycle with in_valid=0 treats din as 0.
REQ-015 dly_en = 1 on the IDLE->RUN cycle and on every RUN cycle; 0 in IDLE otherwise.
REQ-016 Phase A (cnt 0,1): to_dly = din; next dout = dly, with cnt=1 applying the -j twiddle: out_r = dly_i, out_i = -dly_r (wrap on negating the most-negative value).
REQ-017 Phase B (cnt 2,3): next dout = dly + din; to_dly = dly - din; both computed at WIDTH+1 bits.
REQ-018 Width rule, SCALE=0: low WIDTH bits kept (two's-complement wrap). SCALE=1: bits [WIDTH:1] kept.
REQ-019 Output order per block x0..x3: x0+x2, x1+x3, x0-x2, -j(x1-x3).
REQ-020 Latency: sums appear 1 cycle after x2/x3 are accepted. Differences appear 1 cycle after cnt 0/1 of the following block.
REQ-021 A 2-deep valid-tag shift (vt) runs in lockstep with the delay line.
REQ-022 vt write value: in_valid in phase A; vt_out | in_valid in phase B.
REQ-023 out_valid next value: vt_out in phase A; vt_out | in_valid in phase B. Thus a trailing partial block flushes fully and idle blocks give out_valid=0.
REQ-024 While in_valid=0 and vt is all zero, dout is still computed (zeros from a cleared delay line); only out_valid qualifies it.
REQ-025 The delay line's active-high reset is driven by ~reset_n at integration; the delay line latency equals exactly 2 dly_en strobes.

Reset
REQ-026 reset_n=0 immediately forces: state IDLE, cnt=0, vt=0, dout_r=dout_i=0, out_valid=0. to_dly and dly_en follow IDLE rules.
REQ-027 Reset asserted mid-block discards all in-flight data; the first in_valid after release is treated as x0 of a new block.
REQ-028 No synchronous clear; reset_n is the only way to return to IDLE.

Verification
REQ-029 SCALE=0, inputs (1,0),(2,0),(3,0),(4,0) on consecutive cycles, then in_valid=0 -> outputs (4,0),(6,0),(-2,0),(0,2) with out_valid=1 for exactly those 4 cycles.
REQ-030 Two back-to-back blocks 1..4 then 5..8 (real) -> 4,6,-2,(0,2),12,14,-2,(0,2) contiguous with out_valid held 1.
REQ-031 Overflow: x0=x2=0x7FFFFF real. SCALE=0 -> sum 0xFFFFFE (-2). SCALE=1 -> sum 0x7FFFFF and difference 0.
REQ-032 Partial block: only x0=(5,-3), x1=(1,1) valid, then in_valid=0 -> (5,-3),(1,1),(5,-3),(1,-1) flushed with out_valid=1, then out_valid=0.
REQ-033 reset_n pulsed low during cnt=3 -> all outputs 0 in the same cycle. After release, a block 1..4 reproduces REQ-029 exactly.
REQ-034 Gap inside a block: x1 has in_valid=0 -> treated as 0, outputs per REQ-019 with x1=0, out_valid per REQ-023.

Source files
------------

// File: rtl/radix2_bf_dl2.sv
`default_nettype none
// ==== radix2_bf_dl2 : radix-2 SDF butterfly, 4-point stage, external 2-deep feedback delay line ====
// ==== Rev 1.0 ====
module radix2_bf_dl2 #(
  parameter int WIDTH = 24,
  parameter int SCALE = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] din_r,
  input  logic [WIDTH-1:0] din_i,
  input  logic [WIDTH-1:0] dly_r,
  input  logic [WIDTH-1:0] dly_i,
  output logic             dly_en,
  output logic [WIDTH-1:0] to_dly_r,
  output logic [WIDTH-1:0] to_dly_i,
  output logic [WIDTH-1:0] dout_r,
  output logic [WIDTH-1:0] dout_i,
  output logic             out_valid
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [1:0]       cnt_q, cnt_d;
  logic [1:0]       vt_q, vt_d;
  logic [WIDTH-1:0] dout_r_q, dout_r_d;
  logic [WIDTH-1:0] dout_i_q, dout_i_d;
  logic             out_valid_q, out_valid_d;

  logic [WIDTH-1:0] w_din_r, w_din_i;
  logic [WIDTH:0]   w_sum_r, w_sum_i, w_dif_r, w_dif_i;
  logic [WIDTH-1:0] w_sum_r_s, w_sum_i_s, w_dif_r_s, w_dif_i_s;
  logic             w_vt_in;

  assign w_din_r = in_valid ? din_r : '0;
  assign w_din_i = in_valid ? din_i : '0;

  assign w_sum_r = {dly_r[WIDTH-1], dly_r} + {w_din_r[WIDTH-1], w_din_r};
  assign w_sum_i = {dly_i[WIDTH-1], dly_i} + {w_din_i[WIDTH-1], w_din_i};
  assign w_dif_r = {dly_r[WIDTH-1], dly_r} - {w_din_r[WIDTH-1], w_din_r};
  assign w_dif_i = {dly_i[WIDTH-1], dly_i} - {w_din_i[WIDTH-1], w_din_i};

  // Scaling keeps the top WIDTH bits of the WIDTH+1 result; otherwise wrap to WIDTH.
  assign w_sum_r_s = (SCALE != 0) ? w_sum_r[WIDTH:1] : w_sum_r[WIDTH-1:0];
  assign w_sum_i_s = (SCALE != 0) ? w_sum_i[WIDTH:1] : w_sum_i[WIDTH-1:0];
  assign w_dif_r_s = (SCALE != 0) ? w_dif_r[WIDTH:1] : w_dif_r[WIDTH-1:0];
  assign w_dif_i_s = (SCALE != 0) ? w_dif_i[WIDTH:1] : w_dif_i[WIDTH-1:0];

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    vt_d        = vt_q;
    dly_en      = 1'b0;
    to_dly_r    = w_din_r;
    to_dly_i    = w_din_i;
    dout_r_d    = dly_r;
    dout_i_d    = dly_i;
    out_valid_d = vt_q[1];
    w_vt_in     = in_valid;

    if (state_q == IDLE && in_valid) begin
      state_d = RUN;
    end

    if (cnt_q[1]) begin
      to_dly_r    = w_dif_r_s;
      to_dly_i    = w_dif_i_s;
      dout_r_d    = w_sum_r_s;
      dout_i_d    = w_sum_i_s;
      out_valid_d = vt_q[1] | in_valid;
      w_vt_in     = vt_q[1] | in_valid;
    end else if (cnt_q[0]) begin
      // -j twiddle on the returning difference
      dout_r_d = dly_i;
      dout_i_d = -dly_r;
    end

    if (state_q == RUN || in_valid) begin
      dly_en = 1'b1;
      cnt_d  = cnt_q + 2'd1;
      vt_d   = {vt_q[0], w_vt_in};
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      vt_q        <= '0;
      dout_r_q    <= '0;
      dout_i_q    <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      vt_q        <= vt_d;
      dout_r_q    <= dout_r_d;
      dout_i_q    <= dout_i_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign dout_r    = dout_r_q;
  assign dout_i    = dout_i_q;
  assign out_valid = out_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_radix2_bf_dl2.sv
`default_nettype none
// tb_radix2_bf_dl2 : checks radix2_bf_dl2 at SCALE=0 and SCALE=1 against a block-level FFT model.
module tb_radix2_bf_dl2;
  localparam int W = 24;

  logic         clk      = 1'b0;
  logic         reset_n  = 1'b1;
  logic         in_valid = 1'b0;
  logic [W-1:0] din_r    = '0;
  logic [W-1:0] din_i    = '0;

  logic [W-1:0] dly_r0, dly_i0, to_dly_r0, to_dly_i0, dout_r0, dout_i0;
  logic [W-1:0] dly_r1, dly_i1, to_dly_r1, to_dly_i1, dout_r1, dout_i1;
  logic         dly_en0, out_valid0, dly_en1, out_valid1;

  logic [W-1:0] dl_r0 [2];
  logic [W-1:0] dl_i0 [2];
  logic [W-1:0] dl_r1 [2];
  logic [W-1:0] dl_i1 [2];

  int vectors    = 0;
  int miscompares = 0;

  longint xr_m [2048];
  longint xi_m [2048];
  bit     vs_m [2048];
  int     n_m     = 0;
  bit     running = 1'b0;
  int     m_vis   = 0;
  logic   en_s0, en_s1;
  logic [99:0] exp_vec;
  logic [99:0] got_vec;

  assign got_vec = {dout_r0, dout_i0, out_valid0, dout_r1, dout_i1, out_valid1, en_s0, en_s1};

  always #5 clk = ~clk;

  radix2_bf_dl2 #(.WIDTH(W), .SCALE(0)) dut0 (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .din_r(din_r), .din_i(din_i),
    .dly_r(dly_r0), .dly_i(dly_i0), .dly_en(dly_en0), .to_dly_r(to_dly_r0), .to_dly_i(to_dly_i0),
    .dout_r(dout_r0), .dout_i(dout_i0), .out_valid(out_valid0)
  );

  radix2_bf_dl2 #(.WIDTH(W), .SCALE(1)) dut1 (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .din_r(din_r), .din_i(din_i),
    .dly_r(dly_r1), .dly_i(dly_i1), .dly_en(dly_en1), .to_dly_r(to_dly_r1), .to_dly_i(to_dly_i1),
    .dout_r(dout_r1), .dout_i(dout_i1), .out_valid(out_valid1)
  );

  // External 2-deep delay lines (shift_2), reset by ~reset_n
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dl_r0[0] <= '0; dl_r0[1] <= '0; dl_i0[0] <= '0; dl_i0[1] <= '0;
    end else if (dly_en0) begin
      dl_r0[0] <= to_dly_r0; dl_r0[1] <= dl_r0[0];
      dl_i0[0] <= to_dly_i0; dl_i0[1] <= dl_i0[0];
    end
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dl_r1[0] <= '0; dl_r1[1] <= '0; dl_i1[0] <= '0; dl_i1[1] <= '0;
    end else if (dly_en1) begin
      dl_r1[0] <= to_dly_r1; dl_r1[1] <= dl_r1[0];
      dl_i1[0] <= to_dly_i1; dl_i1[1] <= dl_i1[0];
    end
  end
  assign dly_r0 = dl_r0[1];
  assign dly_i0 = dl_i0[1];
  assign dly_r1 = dl_r1[1];
  assign dly_i1 = dl_i1[1];

  function automatic longint wrapw(input longint s, input int sc);
    longint t;
    t = s >>> sc;
    t = t & ((64'sd1 <<< W) - 1);
    if (t[W-1]) t = t - (64'sd1 <<< W);
    return t;
  endfunction

  // Expected output visible during cycle m of a run (m=0: idle/pre-start).
  // Block k occupies cycles 4k..4k+3; its outputs appear at 4k+3..4k+6.
  task automatic model(input int m, input int sc, output longint er, output longint ei, output bit ev);
    int b;
    longint dr, di;
    er = 0; ei = 0; ev = 1'b0;
    if (m >= 3) begin
      case (m % 4)
        3: begin
          b = m - 3;
          er = wrapw(xr_m[b] + xr_m[b+2], sc); ei = wrapw(xi_m[b] + xi_m[b+2], sc);
          ev = vs_m[b] | vs_m[b+2];
        end
        0: begin
          b = m - 4;
          er = wrapw(xr_m[b+1] + xr_m[b+3], sc); ei = wrapw(xi_m[b+1] + xi_m[b+3], sc);
          ev = vs_m[b+1] | vs_m[b+3];
        end
        1: if (m >= 5) begin
          b = m - 5;
          er = wrapw(xr_m[b] - xr_m[b+2], sc); ei = wrapw(xi_m[b] - xi_m[b+2], sc);
          ev = vs_m[b] | vs_m[b+2];
        end
        default: if (m >= 6) begin
          b = m - 6;
          dr = wrapw(xr_m[b+1] - xr_m[b+3], sc); di = wrapw(xi_m[b+1] - xi_m[b+3], sc);
          er = di; ei = wrapw(-dr, 0);
          ev = vs_m[b+1] | vs_m[b+3];
        end
      endcase
    end
  endtask

  // Drive one cycle and produce the expected post-edge outputs in exp_vec.
  task automatic step(input bit v, input longint xr, input longint xi);
    longint er0, ei0, er1, ei1;
    bit ev;
    @(negedge clk);
    in_valid = v; din_r = xr[W-1:0]; din_i = xi[W-1:0];
    if (!running && v) begin running = 1'b1; n_m = 0; end
    m_vis = 0;
    if (running) begin
      xr_m[n_m] = v ? wrapw(xr, 0) : 0;
      xi_m[n_m] = v ? wrapw(xi, 0) : 0;
      vs_m[n_m] = v;
      n_m++;
      m_vis = n_m;
    end
    #1; en_s0 = dly_en0; en_s1 = dly_en1;
    @(posedge clk); #1;
    model(m_vis, 0, er0, ei0, ev);
    model(m_vis, 1, er1, ei1, ev);
    exp_vec = {er0[W-1:0], ei0[W-1:0], ev, er1[W-1:0], ei1[W-1:0], ev, running, running};
  endtask

  task automatic do_reset;
    @(negedge clk); in_valid = 1'b0; reset_n = 1'b0;
    @(negedge clk); reset_n = 1'b1; running = 1'b0;
  endtask

  task automatic test_reset;
    @(negedge clk);
    din_r = 24'h123456; din_i = 24'h654321; in_valid = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    vectors++;
    if ({dout_r0, dout_i0, out_valid0, dout_r1, dout_i1, out_valid1, dly_en0, dly_en1} !== '0) begin
      miscompares++;
      $display("FAIL reset got=%h exp=0", {dout_r0, dout_i0, out_valid0, dout_r1, dout_i1, out_valid1, dly_en0, dly_en1});
    end
    @(negedge clk); reset_n = 1'b1; running = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(1'b0, longint'($urandom), longint'($urandom));
      vectors++;
      if (got_vec !== exp_vec) begin
        miscompares++;
        $display("FAIL reset_idle m=%0d got=%h exp=%h", m_vis, got_vec, exp_vec);
      end
    end
  endtask

  task automatic test_single_block;
    int er_t [8] = '{0, 0, 4, 6, -2, 0, 0, 0};
    int ei_t [8] = '{0, 0, 0, 0, 0, 2, 0, 0};
    bit ev_t [8] = '{0, 0, 1, 1, 1, 1, 0, 0};
    logic [W-1:0] tr, ti;
    for (int i = 0; i < 8; i++) begin
      step(i < 4, (i < 4) ? longint'(i + 1) : 0, 0);
      vectors++;
      if (got_vec !== exp_vec) begin
        miscompares++;
        $display("FAIL single m=%0d got=%h exp=%h", m_vis, got_vec, exp_vec);
      end
      tr = W'(er_t[i]); ti = W'(ei_t[i]);
      vectors++;
      if ({dout_r0, dout_i0, out_valid0} !== {tr, ti, ev_t[i]}) begin
        miscompares++;
        $display("FAIL single_lit i=%0d got=%h %h %b exp=%h %h %b", i, dout_r0, dout_i0, out_valid0, tr, ti, ev_t[i]);
      end
    end
  endtask

  task automatic test_back_to_back;
    int er_t [12] = '{0, 0, 4, 6, -2, 0, 12, 14, -2, 0, 0, 0};
    int ei_t [12] = '{0, 0, 0, 0, 0, 2, 0, 0, 0, 2, 0, 0};
    bit ev_t [12] = '{0, 0, 1, 1, 1, 1, 1, 1, 1, 1, 0, 0};
    logic [W-1:0] tr, ti;
    do_reset();
    for (int i = 0; i < 12; i++) begin
      step(i < 8, (i < 8) ? longint'(i + 1) : 0, 0);
      vectors++;
      if (got_vec !== exp_vec) begin
        miscompares++;
        $display("FAIL b2b m=%0d got=%h exp=%h", m_vis, got_vec, exp_vec);
      end
      tr = W'(er_t[i]); ti = W'(ei_t[i]);
      vectors++;
      if ({dout_r0, dout_i0, out_valid0} !== {tr, ti, ev_t[i]}) begin
        miscompares++;
        $display("FAIL b2b_lit i=%0d got=%h %h %b exp=%h %h %b", i, dout_r0, dout_i0, out_valid0, tr, ti, ev_t[i]);
      end
    end
  endtask

  task automatic test_overflow;
    longint xs [4] = '{longint'(24'h7FFFFF), -longint'(1 << 23), longint'(24'h7FFFFF), 0};
    do_reset();
    for (int i = 0; i < 8; i++) begin
      step(i < 4, (i < 4) ? xs[i] : 0, 0);
      vectors++;
      if (got_vec !== exp_vec) begin
        miscompares++;
        $display("FAIL overflow m=%0d got=%h exp=%h", m_vis, got_vec, exp_vec);
      end
      if (i == 2) begin
        vectors++;
        if ({dout_r0, dout_r1} !== {24'hFFFFFE, 24'h7FFFFF}) begin
          miscompares++;
          $display("FAIL overflow_sum got=%h %h exp=fffffe 7fffff", dout_r0, dout_r1);
        end
      end
      if (i == 4) begin
        vectors++;
        if ({dout_r0, dout_r1} !== '0) begin
          miscompares++;
          $display("FAIL overflow_dif got=%h %h exp=0 0", dout_r0, dout_r1);
        end
      end
      if (i == 5) begin
        vectors++;
        if ({dout_i0, dout_i1} !== {24'h800000, 24'h400000}) begin
          miscompares++;
          $display("FAIL overflow_negj got=%h %h exp=800000 400000", dout_i0, dout_i1);
        end
      end
    end
  endtask

  task automatic test_partial;
    int er_t [8] = '{0, 0, 5, 1, 5, 1, 0, 0};
    int ei_t [8] = '{0, 0, -3, 1, -3, -1, 0, 0};
    bit ev_t [8] = '{0, 0, 1, 1, 1, 1, 0, 0};
    logic [W-1:0] tr, ti;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      if (i == 0)      step(1'b1, 5, -3);
      else if (i == 1) step(1'b1, 1, 1);
      else             step(1'b0, longint'($urandom), longint'($urandom));
      vectors++;
      if (got_vec !== exp_vec) begin
        miscompares++;
        $display("FAIL partial m=%0d got=%h exp=%h", m_vis, got_vec, exp_vec);
      end
      tr = W'(er_t[i]); ti = W'(ei_t[i]);
      vectors++;
      if ({dout_r0, dout_i0, out_valid0} !== {tr, ti, ev_t[i]}) begin
        miscompares++;
        $display("FAIL partial_lit i=%0d got=%h %h %b exp=%h %h %b", i, dout_r0, dout_i0, out_valid0, tr, ti, ev_t[i]);
      end
    end
  endtask

  task automatic test_gap;
    do_reset();
    for (int i = 0; i < 12; i++) begin
      step((i != 1) && (i < 8), longint'($urandom), longint'($urandom));
      vectors++;
      if (got_vec !== exp_vec) begin
        miscompares++;
        $display("FAIL gap m=%0d got=%h exp=%h", m_vis, got_vec, exp_vec);
      end
    end
  endtask

  task automatic test_midblock_reset;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      step(1'b1, longint'($urandom), longint'($urandom));
      vectors++;
      if (got_vec !== exp_vec) begin
        miscompares++;
        $display("FAIL midrst_pre m=%0d got=%h exp=%h", m_vis, got_vec, exp_vec);
      end
    end
    @(negedge clk);
    in_valid = 1'b1; din_r = 24'h000777; din_i = 24'h000333;
    #2 reset_n = 1'b0; in_valid = 1'b0;
    #1;
    vectors++;
    if ({dout_r0, dout_i0, out_valid0, dout_r1, dout_i1, out_valid1, dly_en0, dly_en1,
         to_dly_r0, to_dly_i0, to_dly_r1, to_dly_i1} !== '0) begin
      miscompares++;
      $display("FAIL midrst got=%h %h %b %h %h %b en=%b%b", dout_r0, dout_i0, out_valid0,
               dout_r1, dout_i1, out_valid1, dly_en0, dly_en1);
    end
    @(negedge clk); reset_n = 1'b1; running = 1'b0;
    test_single_block();
  endtask

  task automatic test_random;
    bit v;
    do_reset();
    for (int i = 0; i < 500; i++) begin
      if (i == 250) do_reset();
      v = (i > 320 && i < 420) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      step(v, longint'($urandom), longint'($urandom));
      vectors++;
      if (got_vec !== exp_vec) begin
        miscompares++;
        $display("FAIL random i=%0d m=%0d got=%h exp=%h", i, m_vis, got_vec, exp_vec);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_block();
    test_back_to_back();
    test_overflow();
    test_partial();
    test_gap();
    test_midblock_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
